// File: rtl/gauss3x3.sv
// Streaming 3x3 Gaussian blur over a zero-padded raster, kernel [1 2 1; 2 4 2; 1 2 1] / 16 rounded.
// Two line buffers supply the upper rows; a shift window holds the columns already seen.
module gauss3x3 #(
  parameter int WIDTH  = 6,
  parameter int HEIGHT = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  input  logic       ready_in
);

  localparam int PW = WIDTH + 2;
  localparam int PH = HEIGHT + 2;
  localparam int XW = (PW > 1) ? $clog2(PW) : 1;
  localparam int YW = (PH > 1) ? $clog2(PH) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  logic [7:0] lb0_q [PW];
  logic [7:0] lb1_q [PW];

  // Window: index 0 is the centre column of the next sum, index 1 its left column.
  // The column leaving on each shift is never read again, so only two are kept.
  logic [1:0][7:0] top_q, top_d;
  logic [1:0][7:0] mid_q, mid_d;
  logic [1:0][7:0] bot_q, bot_d;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  logic       accept;
  logic       emit;
  logic [7:0] colTop, colMid, colBot;
  logic [11:0] rowTop, rowMid, rowBot, sum;

  function automatic logic [11:0] row121(input logic [7:0] l, input logic [7:0] c,
                                         input logic [7:0] r);
    return {4'd0, l} + {3'd0, c, 1'b0} + {4'd0, r};
  endfunction

  assign ready_out = ready_in | ~valid_q;
  assign accept    = valid_in & ready_out;
  assign emit      = (x_q >= XW'(2)) && (y_q >= YW'(2));

  assign colTop = lb1_q[x_q];
  assign colMid = lb0_q[x_q];
  assign colBot = data_in;

  assign rowTop = row121(top_q[1], top_q[0], colTop);
  assign rowMid = row121(mid_q[1], mid_q[0], colMid);
  assign rowBot = row121(bot_q[1], bot_q[0], colBot);
  assign sum    = rowTop + (rowMid << 1) + rowBot;

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    top_d   = top_q;
    mid_d   = mid_q;
    bot_d   = bot_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (accept) begin
      if (x_q == XW'(PW - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(PH - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      top_d = {top_q[0], colTop};
      mid_d = {mid_q[0], colMid};
      bot_d = {bot_q[0], colBot};
      if (emit) begin
        data_d  = 8'((sum + 12'd8) >> 4);
        valid_d = 1'b1;
      end else if (ready_in) begin
        valid_d = 1'b0;
      end
    end else if (ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      top_q   <= '0;
      mid_q   <= '0;
      bot_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      top_q   <= top_d;
      mid_q   <= mid_d;
      bot_q   <= bot_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Line buffers carry no reset: the first two rows of every frame refill them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[x_q] <= lb0_q[x_q];
      lb0_q[x_q] <= data_in;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: doc/gauss3x3.md
Name: gauss3x3

Overview:
Streaming 3x3 Gaussian blur stage that sits directly downstream of the zero-padding stage. It consumes a padded 8-bit raster of (WIDTH+2) x (HEIGHT+2) pixels and produces a filtered WIDTH x HEIGHT raster. Two internal line buffers and a 3x3 shift window are used, with a valid/ready handshake on both sides. Kernel [1 2 1; 2 4 2; 1 2 1], rounded divide by 16.

Parameters:
WIDTH, 6, unpadded image width in pixels; the input row length is PW = WIDTH+2.
HEIGHT, 6, unpadded image height in pixels; the input frame is PH = HEIGHT+2 rows.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
data_in  input  8  padded pixel, raster order.
valid_in  input  1  data_in is valid.
ready_out  output  1  block accepts data_in this cycle.
data_out  output  8  filtered pixel, raster order.
valid_out  output  1  data_out is valid.
ready_in  input  1  downstream accepts data_out.

Behaviour:
- Interface: one clock `clk`; `reset` is asynchronous and active-high. All state clears immediately on reset assertion.
- Reset values: data_out=0, valid_out=0, column counter x=0, row counter y=0, window registers=0.
- Combinational ready: ready_out = ready_in | ~valid_out.
- Accept: occurs when valid_in & ready_out. No state changes on cycles without an accept, except that valid_out drops when the output is taken.
- Output hold: while valid_out=1 and ready_in=0, data_out and valid_out are held stable.
- Counters: x counts 0..PW-1 and y counts 0..PH-1, both advancing on accept. When x=PW-1, x wraps to 0 and y increments. When x=PW-1 and y=PH-1, both wrap to 0; the next frame follows back-to-back with no gap cycles.
- Line buffers: lb0 holds row y-1 and lb1 holds row y-2, each PW x 8 bits. On accept at column x, read lb0[x] and lb1[x], then write lb1[x] <= lb0[x] and lb0[x] <= data_in.
- Line buffer reset: contents are not reset. Rows 0 and 1 overwrite them before any output uses them.
- Window: 3 columns x 3 rows. On accept, the window shifts left by one column. The new right column is {lb1[x], lb0[x], data_in}, top to bottom.
- Output emission: on an accept with x>=2 and y>=2, the window centre maps to output pixel (x-2, y-2). Register data_out <= (S+8)>>4 and set valid_out <= 1.
- No emission: on an accept with x<2 or y<2, clear valid_out if ready_in=1.
- Latency: 1 cycle from the accepting edge to valid_out.
- Output count: exactly WIDTH*HEIGHT outputs per PW*PH inputs.
- Arithmetic: S is a 12-bit weighted sum with maximum 4080. Rounding add makes the maximum 4088, so the result is at most 255 and no saturation is needed. Unsigned throughout.
- Simultaneous events: on a cycle with output taken and a new accept, the new result replaces the old with no bubble. Full throughput is 1 pixel/clock when ready_in is held at 1.
- Upstream gaps: valid_in=0 stalls everything except output drain.
- Reset mid-frame: the partial frame is discarded. The next accepted pixel is treated as padded (0,0).

Test Plan:
- Corner/edge/interior values: WIDTH=HEIGHT=4, padded frame with zero border and interior all 160, ready_in=1 -> output rows 90,120,120,90 / 120,160,160,120 / 120,160,160,120 / 90,120,120,90; 16 outputs.
- Impulse: WIDTH=HEIGHT=6, single 255 at unpadded (2,2) -> output (2,2)=64; (1,2),(3,2),(2,1),(2,3)=32; the four diagonals=16; all other 27 outputs=0.
- Backpressure: ready_in toggling 1-0-0-1 random, valid_in always 1 -> same output sequence as ready_in=1; data_out stable while valid_out & ~ready_in; ready_out=0 exactly in those cycles.
- Input gaps: random valid_in deassertion with two back-to-back frames -> 2*WIDTH*HEIGHT outputs, identical to the gap-free results.
- Reset mid-frame: assert reset after 20 accepts -> valid_out=0 and data_out=0 immediately; the following full frame gives correct results and exactly WIDTH*HEIGHT outputs.
- Saturation: interior all 255 -> interior outputs 255 and corner outputs (2295+8)>>4=143, with no overflow.
